// File: rtl/ds_pkg.sv
// Shared widths and FSM state encoding for the image down-sampling master.
package ds_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned PIX_W  = 8;
  // Four 8-bit pixels sum to at most 1020, which fits in 10 bits.
  localparam int unsigned ACC_W  = 10;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StRd3,
    StWr,
    StDone
  } ds_state_e;

endpackage

// File: rtl/ds_addr_gen.sv
// Output-pixel counters and source/destination address generation.
// The counters walk the down-sampled image row by row with the column
// counter running fastest; quad selects one pixel of the 2x2 source block.
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int unsigned       IMG_W    = 256,
  parameter logic [ADDR_W-1:0] SRC_BASE = 24'd0,
  parameter logic [ADDR_W-1:0] DST_BASE = 24'd131072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [1:0]        quad,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned LOG_W  = $clog2(IMG_W);
  // Keep the counters at least one bit wide for the degenerate 2x2 image.
  localparam int unsigned CNT_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(HALF_W - 1);

  logic [CNT_W-1:0]  r_q, r_d;
  logic [CNT_W-1:0]  c_q, c_d;
  logic [ADDR_W-1:0] r_ext, c_ext;
  logic [ADDR_W-1:0] blk_base;

  // Next counter values: clear on a new pass, step column then row after each write.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clear) begin
      r_d = '0;
      c_d = '0;
    end else if (advance) begin
      if (c_q == CntMax) begin
        c_d = '0;
        r_d = (r_q == CntMax) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  // Address arithmetic; all sums wrap modulo 2^ADDR_W.
  always_comb begin
    r_ext    = ADDR_W'(r_q);
    c_ext    = ADDR_W'(c_q);
    blk_base = SRC_BASE + (r_ext << (LOG_W + 1)) + (c_ext << 1);
    src_addr = blk_base + (quad[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(quad[0]);
    dst_addr = DST_BASE + (r_ext << (LOG_W - 1)) + c_ext;
    last     = (r_q == CntMax) && (c_q == CntMax);
  end

endmodule

// File: rtl/ds_mem_master.sv
// Memory-side initiator: reads each 2x2 block of the source image, averages
// it with a truncating divide by four and writes one output word per block.
module ds_mem_master
  import ds_pkg::*;
#(
  parameter int unsigned       IMG_W    = 256,
  parameter logic [ADDR_W-1:0] SRC_BASE = 24'd0,
  parameter logic [ADDR_W-1:0] DST_BASE = 24'd131072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ds_state_e         state_q, state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [PIX_W-1:0]  pix;
  logic [1:0]        quad;
  logic              ag_clear, ag_advance, ag_last;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic              unused_rdata;

  assign pix          = mem_rdata[PIX_W-1:0];
  assign unused_rdata = ^mem_rdata[DATA_W-1:PIX_W];
  assign ag_clear     = (state_q == StIdle) && start;
  assign ag_advance   = (state_q == StWr);

  ds_addr_gen #(
    .IMG_W   (IMG_W),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (ag_clear),
    .advance (ag_advance),
    .quad    (quad),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .last    (ag_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRd0;
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StRd3;
      StRd3:   state_d = StWr;
      StWr:    state_d = ag_last ? StDone : StRd0;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Block accumulator: load on the first read, add on the remaining three.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      unique case (state_q)
        StRd0:               acc_q <= ACC_W'(pix);
        StRd1, StRd2, StRd3: acc_q <= acc_q + ACC_W'(pix);
        default:             acc_q <= acc_q;
      endcase
    end
  end

  // Output decode; strobes are masked by reset so no access lands on a reset edge.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    quad      = 2'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StRd0, StRd1, StRd2, StRd3: begin
        unique case (state_q)
          StRd1:   quad = 2'd1;
          StRd2:   quad = 2'd2;
          StRd3:   quad = 2'd3;
          default: quad = 2'd0;
        endcase
        mem_read = !reset;
        mem_addr = src_addr;
      end
      StWr: begin
        mem_write = !reset;
        mem_addr  = dst_addr;
        mem_wdata = {{(DATA_W - PIX_W){1'b0}}, acc_q[ACC_W-1:2]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ds_mem_master.sv
// Directed bench for ds_mem_master: a 4x4 instance against a cycle table and
// hand sequences, and an 8x8 in-place instance against a block-average model.
module tb_ds_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // 4x4 instance, destination at the default base.
  logic        reset4, start4, busy4, done4, rd4, wr4;
  logic [23:0] addr4, wdata4, rdata4;
  logic [7:0]  src4 [16];
  logic [15:0] hi4;

  ds_mem_master #(.IMG_W(4), .SRC_BASE(24'd0), .DST_BASE(24'd131072)) dut4 (
    .clk      (clk),
    .reset    (reset4),
    .start    (start4),
    .busy     (busy4),
    .done     (done4),
    .mem_addr (addr4),
    .mem_read (rd4),
    .mem_write(wr4),
    .mem_wdata(wdata4),
    .mem_rdata(rdata4)
  );

  assign rdata4 = {hi4, src4[addr4[3:0]]};

  typedef struct packed {
    logic [23:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t wq4[$];
  int  done_cnt4 = 0;

  always @(posedge clk) begin
    if (wr4) wq4.push_back({addr4, wdata4});
    if (done4) done_cnt4++;
  end

  // 8x8 in-place instance.
  logic        reset8, start8, busy8, done8, rd8, wr8;
  logic [23:0] addr8, wdata8, rdata8;
  logic [23:0] mem8 [64];

  ds_mem_master #(.IMG_W(8), .SRC_BASE(24'd0), .DST_BASE(24'd0)) dut8 (
    .clk      (clk),
    .reset    (reset8),
    .start    (start8),
    .busy     (busy8),
    .done     (done8),
    .mem_addr (addr8),
    .mem_read (rd8),
    .mem_write(wr8),
    .mem_wdata(wdata8),
    .mem_rdata(rdata8)
  );

  assign rdata8 = mem8[addr8[5:0]];

  always @(posedge clk) begin
    if (wr8) mem8[addr8[5:0]] <= wdata8;
  end

  // Bus protocol: exclusive strobes, addresses inside their regions.
  always @(negedge clk) begin
    if (rd4 || wr4) check("proto4_excl", 64'(rd4 & wr4), 64'd0);
    if (rd4) check("proto4_rd_range", 64'(addr4 < 24'd16), 64'd1);
    if (wr4) check("proto4_wr_range", 64'(addr4 >= 24'd131072 && addr4 <= 24'd131075), 64'd1);
    if (rd8 || wr8) check("proto8_excl", 64'(rd8 & wr8), 64'd0);
    if (rd8) check("proto8_rd_range", 64'(addr8 < 24'd64), 64'd1);
    if (wr8) check("proto8_wr_range", 64'(addr8 < 24'd16), 64'd1);
  end

  typedef struct {
    logic        start;
    logic        busy;
    logic        done;
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [23:0] wdata;
  } vec_t;

  vec_t        vecs [23];
  logic [23:0] rd_tab [16];
  logic [23:0] wr_addr [4];
  logic [23:0] wr_data [4];
  logic [7:0]  ref8 [64];
  logic [7:0]  exp8 [16];

  function automatic vec_t mk(logic s, logic b, logic d, logic r, logic w,
                              logic [23:0] a, logic [23:0] wd);
    vec_t v;
    v.start = s; v.busy = b; v.done = d; v.rd = r; v.wr = w; v.addr = a; v.wdata = wd;
    return v;
  endfunction

  task automatic pulse_start(input bit which8);
    @(negedge clk);
    if (which8) start8 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
  endtask

  // Counts cycles from the current one until done is seen, bounded by budget.
  task automatic wait_done(input bit which8, input int budget, output int cyc);
    cyc = 1;
    #1;
    while (!(which8 ? done8 : done4) && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("done_seen", 64'(which8 ? done8 : done4), 64'd1);
  endtask

  task automatic model8();
    int s;
    for (int i = 0; i < 64; i++) ref8[i] = mem8[i][7:0];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = int'(ref8[16*r + 2*c]) + int'(ref8[16*r + 2*c + 1]) +
            int'(ref8[16*r + 8 + 2*c]) + int'(ref8[16*r + 8 + 2*c + 1]);
        exp8[4*r + c] = 8'(s / 4);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    int d0;

    reset4 = 1'b1; reset8 = 1'b1; start4 = 1'b0; start8 = 1'b0; hi4 = 16'h0;
    for (int i = 0; i < 16; i++) src4[i] = 8'(i);
    for (int i = 0; i < 64; i++) mem8[i] = {16'($urandom_range(0, 65535)), 8'((i * 37 + 11) % 256)};

    rd_tab  = '{24'd0, 24'd1, 24'd4, 24'd5, 24'd2, 24'd3, 24'd6, 24'd7,
                24'd8, 24'd9, 24'd12, 24'd13, 24'd10, 24'd11, 24'd14, 24'd15};
    wr_addr = '{24'd131072, 24'd131073, 24'd131074, 24'd131075};
    wr_data = '{24'd2, 24'd4, 24'd10, 24'd12};
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++)
        vecs[1 + 5*p + k] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rd_tab[4*p + k], 24'd0);
      vecs[5 + 5*p] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, wr_addr[p], wr_data[p]);
    end
    vecs[21] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0);

    repeat (2) @(negedge clk);
    reset4 = 1'b0;
    reset8 = 1'b0;
    #1;
    check("reset4_outputs", 64'({busy4, done4, rd4, wr4, addr4, wdata4}), 64'd0);
    check("reset8_outputs", 64'({busy8, done8, rd8, wr8, addr8, wdata8}), 64'd0);

    // 4x4 pass, cycle by cycle.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      start4 = vecs[i].start;
      #1;
      check($sformatf("vec%0d", i), 64'({busy4, done4, rd4, wr4, addr4, wdata4}),
            64'({vecs[i].busy, vecs[i].done, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata}));
    end
    start4 = 1'b0;
    check("pass4_write_count", 64'(wq4.size()), 64'd4);
    for (int p = 0; p < wq4.size() && p < 4; p++)
      check($sformatf("pass4_write%0d", p), 64'(wq4[p]), 64'({wr_addr[p], wr_data[p]}));

    // Truncation with junk in the upper read-data bits.
    wq4.delete();
    src4[0] = 8'd255; src4[1] = 8'd255; src4[4] = 8'd255; src4[5] = 8'd254;
    hi4 = 16'hFFFF;
    pulse_start(1'b0);
    wait_done(1'b0, 100, cyc);
    check("trunc_write_count", 64'(wq4.size()), 64'd4);
    if (wq4.size() > 0) check("trunc_data", 64'(wq4[0].data), 64'h0000FE);
    src4[0] = 8'd0; src4[1] = 8'd1; src4[4] = 8'd4; src4[5] = 8'd5;
    hi4 = 16'h0;

    // Reset in the second write cycle.
    @(negedge clk);
    wq4.delete();
    d0 = done_cnt4;
    pulse_start(1'b0);
    repeat (9) @(negedge clk);
    #1;
    check("rst_pre_write", 64'({wr4, addr4}), 64'({1'b1, 24'd131073}));
    reset4 = 1'b1;
    #1;
    check("rst_strobes_gated", 64'({rd4, wr4}), 64'd0);
    n = wq4.size();
    @(negedge clk);
    check("rst_no_write", 64'(wq4.size()), 64'(n));
    check("rst_writes_before", 64'(n), 64'd1);
    reset4 = 1'b0;
    #1;
    check("rst_outputs", 64'({busy4, done4, rd4, wr4, addr4, wdata4}), 64'd0);
    check("rst_no_done", 64'(done_cnt4 - d0), 64'd0);
    wq4.delete();
    pulse_start(1'b0);
    wait_done(1'b0, 100, cyc);
    check("rst_rerun_count", 64'(wq4.size()), 64'd4);
    if (wq4.size() > 0) check("rst_rerun_first", 64'(wq4[0]), 64'({24'd131072, 24'd2}));

    // Start pulses during RD2 and during DONE.
    @(negedge clk);
    wq4.delete();
    d0 = done_cnt4;
    pulse_start(1'b0);
    @(negedge clk);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(1'b0, 100, cyc);
    check("busy_start_latency", 64'(cyc), 64'd18);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    #1;
    check("done_start_ignored", 64'(busy4), 64'd0);
    repeat (5) @(negedge clk);
    check("busy_start_idle", 64'(busy4), 64'd0);
    check("busy_start_done_pulses", 64'(done_cnt4 - d0), 64'd1);
    check("busy_start_writes", 64'(wq4.size()), 64'd4);

    // 8x8 in place, then a second pass straight after DONE.
    model8();
    pulse_start(1'b1);
    wait_done(1'b1, 200, cyc);
    check("inplace_latency", 64'(cyc), 64'd81);
    for (int k = 0; k < 16; k++)
      check($sformatf("inplace1_%0d", k), 64'(mem8[k]), 64'({16'h0, exp8[k]}));
    model8();
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    #1;
    check("second_pass_accepted", 64'({busy8, rd8, addr8}), 64'({1'b1, 1'b1, 24'd0}));
    wait_done(1'b1, 200, cyc);
    for (int k = 0; k < 16; k++)
      check($sformatf("inplace2_%0d", k), 64'(mem8[k]), 64'({16'h0, exp8[k]}));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
